// File: rtl/ssm_pkg.sv
// Shared encodings for the control sequencer: opcodes, FSM states, ALU ops
// and instruction field positions.
package ssm_pkg;

  // Instruction field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 0;

  // Opcodes (7..14 are illegal)
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_LDI  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  // FSM states
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_READ_A = 3'd2;
  localparam logic [2:0] ST_READ_B = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // ALU operation codes
  localparam logic [2:0] ALU_PASS_A = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;

  // Map an arithmetic/logic opcode to the ALU operation it needs
  function automatic logic [2:0] alu_op_for(input logic [3:0] opcode);
    case (opcode)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational split of the instruction register into fields plus
// classification flags.
module instruction_decoder
  import ssm_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [5:0]        rd,
  output logic [5:0]        rs,
  output logic              is_alu,
  output logic              is_illegal
);

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];

  // Two-operand ops that read rd and rs and write the ALU result back
  assign is_alu     = (opcode >= OP_ADD) && (opcode <= OP_OR);
  assign is_illegal = (opcode > OP_OR) && (opcode < OP_HALT);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches one instruction at a time and
// drives register-file / ALU / immediate bus controls as a Moore machine.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   FETCH   | ready for a new instruction, IR loads on valid
//   DECODE  | classify IR; NOP/illegal finish here
//   READ_A  | register onto bus, captured into ALU operand A
//   READ_B  | rs onto bus, captured into ALU operand B
//   WRITE   | ALU result or immediate written to rd
//   HALT    | parked until reset
module control_sequencer
  import ssm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic              instruction_valid,
  output logic              instruction_ready,
  output logic [ADDR_W-1:0] register_addr,
  output logic              bus_register_input_en,
  output logic              bus_register_output_en,
  output logic              alu_a_load,
  output logic              alu_b_load,
  output logic [2:0]        alu_op,
  output logic              alu_result_output_en,
  output logic              imm_output_en,
  output logic [DATA_W-1:0] imm_value,
  output logic              instr_done,
  output logic              illegal_op,
  output logic              halted
);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [3:0] opcode;
  logic [5:0] rd, rs;
  logic       is_alu, is_illegal;

  instruction_decoder #(.DATA_W(DATA_W)) u_decoder (
    .ir         (ir_q),
    .opcode     (opcode),
    .rd         (rd),
    .rs         (rs),
    .is_alu     (is_alu),
    .is_illegal (is_illegal)
  );

  // Next-state and instruction-register load
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (instruction_valid) begin
          ir_d    = instruction;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_illegal || opcode == OP_NOP) state_d = ST_FETCH;
        else if (opcode == OP_HALT)         state_d = ST_HALT;
        else if (opcode == OP_LDI)          state_d = ST_WRITE;
        else                                state_d = ST_READ_A;
      end
      ST_READ_A: state_d = (opcode == OP_MOV) ? ST_WRITE : ST_READ_B;
      ST_READ_B: state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // State and IR registers; reset abandons any instruction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Immediate follows IR so it is already stable when WRITE enables it
  assign imm_value = DATA_W'(rs);

  // Bus controls decoded from state and IR only
  always_comb begin
    instruction_ready      = 1'b0;
    register_addr          = '0;
    bus_register_input_en  = 1'b0;
    bus_register_output_en = 1'b0;
    alu_a_load             = 1'b0;
    alu_b_load             = 1'b0;
    alu_op                 = ALU_PASS_A;
    alu_result_output_en   = 1'b0;
    imm_output_en          = 1'b0;
    instr_done             = 1'b0;
    illegal_op             = 1'b0;
    halted                 = 1'b0;
    case (state_q)
      ST_FETCH: instruction_ready = 1'b1;
      ST_DECODE: begin
        illegal_op = is_illegal;
        instr_done = is_illegal || (opcode == OP_NOP);
      end
      ST_READ_A: begin
        register_addr          = (opcode == OP_MOV) ? ADDR_W'(rs) : ADDR_W'(rd);
        bus_register_output_en = 1'b1;
        alu_a_load             = 1'b1;
      end
      ST_READ_B: begin
        register_addr          = ADDR_W'(rs);
        bus_register_output_en = 1'b1;
        alu_b_load             = 1'b1;
      end
      ST_WRITE: begin
        register_addr         = ADDR_W'(rd);
        bus_register_input_en = 1'b1;
        instr_done            = 1'b1;
        if (opcode == OP_LDI) begin
          imm_output_en = 1'b1;
        end else begin
          alu_result_output_en = 1'b1;
          alu_op               = is_alu ? alu_op_for(opcode) : ALU_PASS_A;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bus/instruction width.
REQ-002 SHALL have parameter ADDR_W, default 6, register address width.
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 instruction  input  DATA_W  [15:12] opcode, [11:6] rd, [5:0] rs/imm6.
REQ-006 instruction_valid  input  1  upstream offers instruction.
REQ-007 instruction_ready  output  1  sequencer can accept an instruction.
REQ-008 register_addr  output  ADDR_W  register file address.
REQ-009 bus_register_input_en  output  1  register file writes bus at register_addr.
REQ-010 bus_register_output_en  output  1  register file drives bus.
REQ-011 alu_a_load, alu_b_load  output  1 each  ALU operand latches capture bus.
REQ-012 alu_op  output  3  PASS_A=0, ADD=1, SUB=2, AND=3, OR=4.
REQ-013 alu_result_output_en  output  1  ALU drives bus.
REQ-014 imm_output_en  output  1  sequencer drives imm_value onto bus.
REQ-015 imm_value  output  DATA_W  zero-extended imm6.
REQ-016 instr_done, illegal_op  output  1 each  one-cycle pulses.
REQ-017 halted  output  1  high while in HALT.

Function
REQ-018 Opcodes SHALL be NOP=0, MOV=1 (rd<-rs), LDI=2 (rd<-imm6), ADD=3, SUB=4, AND=5, OR=6 (rd<-rd op rs), HALT=15; 7-14 illegal.
REQ-019 States SHALL be FETCH, DECODE, READ_A, READ_B, WRITE, HALT.
REQ-020 instruction_ready SHALL be 1 only in FETCH; transfer occurs on edge with valid&&ready, latching instruction into IR and entering DECODE.
REQ-021 DECODE: NOP -> FETCH with instr_done; illegal -> FETCH with illegal_op and instr_done; HALT -> HALT; LDI -> WRITE; MOV/ALU ops -> READ_A.
REQ-022 READ_A: MOV drives register_addr=rs, ALU ops register_addr=rd; bus_register_output_en=1, alu_a_load=1; MOV -> WRITE, ALU ops -> READ_B.
REQ-023 READ_B: register_addr=rs, bus_register_output_en=1, alu_b_load=1; -> WRITE.
REQ-024 WRITE: register_addr=rd, bus_register_input_en=1, instr_done=1; LDI asserts imm_output_en, others assert alu_result_output_en with alu_op (PASS_A for MOV); -> FETCH.
REQ-025 Latency from accept edge to instr_done cycle SHALL be: NOP/illegal 1, LDI 2, MOV 3, ALU ops 4 cycles.
REQ-026 At most one of bus_register_output_en, alu_result_output_en, imm_output_en SHALL be high in any cycle.
REQ-027 bus_register_input_en and bus_register_output_en SHALL never be high together.
REQ-028 All enables/loads SHALL be decoded from state and IR only (Moore), never from live instruction input.
REQ-029 instruction changes while not ready SHALL have no effect.
REQ-030 HALT SHALL be exited only by reset; instruction_ready=0, all enables 0, halted=1.
REQ-031 register_addr, alu_op SHALL be 0 in states that do not use them.

Reset
REQ-032 reset SHALL asynchronously force FETCH, IR=0, all enables/loads/pulses/halted=0, register_addr=0, alu_op=0, imm_value=0; instruction_ready=1 after release.
REQ-033 Reset mid-instruction SHALL abandon it with no further register write.

Structure
REQ-034 Package ssm_pkg SHALL hold opcode, state and alu_op encodings plus field bit positions.
REQ-035 One combinational sub-module instruction_decoder SHALL split IR into opcode/rd/rs and flag illegal.

Verification
REQ-036 LDI r5,#0x2A -> WRITE 2 cycles after accept: register_addr=5, imm_value=0x002A, imm_output_en=1, bus_register_input_en=1, instr_done=1.
REQ-037 ADD r3,r7 -> READ_A addr=3, READ_B addr=7, WRITE addr=3 alu_op=1; instr_done 4 cycles after accept.
REQ-038 MOV r1,r63 -> READ_A addr=63 alu_a_load, WRITE addr=1 alu_op=0; done at 3 cycles.
REQ-039 opcode 0x9 -> illegal_op and instr_done 1 cycle after accept, no enables, ready next cycle.
REQ-040 HALT then valid held high -> halted=1, ready=0 indefinitely; reset -> FETCH, ready=1.
REQ-041 reset asserted during READ_B of SUB -> outputs 0 immediately, no bus_register_input_en; bus-driver exclusivity checked every cycle by assertion.
